lzd_pipe: RTL
=============

Name: lzd_pipe

Overview:
- Parametrised, pipelined leading-zero detector; next generation of the team's 31-bit combinational LZD.
- Counts leading zeros of an arbitrary-width word using the same pairwise (position, valid) merge tree, padded to a power of two.
- Adds register stages, a valid/ready handshake, an all-zero flag and optional normalisation output.
- Sits in the FP add/normalise datapath ahead of the normalisation shifter.

Parameters:
- DATA_W, 32, input width; legal range 2..256, need not be a power of two.
- STAGES, 2, number of register stages; legal range 1..LEVELS, where LEVELS = clog2(PAD_W).
- CNT_W, clog2(DATA_W+1), count width; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept an input this cycle
- in_data  in  DATA_W  word to scan; MSB is bit DATA_W-1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_count  out  CNT_W  number of leading zeros, 0..DATA_W
- out_zero  out  1  in_data was all zeros
- out_norm  out  DATA_W  normalised data; present only with LZD_NORM_EN

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n=0: out_valid=0, out_count=0, out_zero=0, out_norm=0, all stage valid bits=0. Reset mid-operation discards in-flight words; no output appears after release until a new input is accepted.
- Padding: in_data is extended at the LSB end with ones to PAD_W = 2^clog2(DATA_W). Padding never affects the count of a nonzero word.
- Tree: level-1 leaf pair j gives v = d[2j+1]|d[2j] and p = ~d[2j+1]. Each merge node gives {~v_hi, v_hi ? p_hi : p_lo} and v = v_hi|v_lo.
- Register placement: register k (k=1..STAGES) sits after tree level ceil(k*LEVELS/STAGES). The last register is the output register, placed after the final level and the final correction.
- Final correction: if the root v=0 (all zero), out_count=DATA_W and out_zero=1. Otherwise out_count = root p (always < DATA_W) and out_zero=0.
- Handshake: adv = ~out_valid | out_ready; in_ready = adv. All stages advance together when adv=1 and hold when adv=0 (global stall).
- Stage valid bits shift with adv, so bubbles propagate and no word is lost or duplicated.
- Latency: an input accepted in cycle t appears with out_valid in cycle t+STAGES when no stall occurs.
- Throughput: one word per cycle while out_ready=1.
- out_* holds stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit in the same cycle is legal.
- Inputs are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro LZD_NORM_EN. When defined: in_data is carried through the pipeline alongside the tree, and out_norm = in_data << out_count, zero-filled from the LSB. An all-zero word gives out_norm=0. The shift lives in the output stage; latency is unchanged.
- When undefined: the out_norm port and its data registers do not exist.

Decomposition:
- Package lzd_pkg holds:
  - clog2 function;
  - PAD_W/LEVELS/CNT_W derivation functions;
  - typedef lzd_node_t {logic v; logic [LEVELS-1:0] p} with unused upper bits zero.
- Sub-module lzd_merge: one combinational merge node, parametrised by level. It is instantiated by generate loops per level; stage registers are inserted between levels per the placement rule.

Test Plan:
- DATA_W=32, STAGES=2, out_ready=1: in 0x0000_0001 -> out_count=31, out_zero=0 at t+2. In 0x8000_0000 -> 0. In 0x0001_2345 -> 15.
- DATA_W=32: in 0x0000_0000 -> out_count=32, out_zero=1. With LZD_NORM_EN, out_norm=0. With LZD_NORM_EN, 0x0001_2345 -> out_norm=0x91A2_8000.
- DATA_W=31, STAGES=1: in 31'h0000_0001 -> out_count=30. In 31'h4000_0000 -> 0. In 0 -> 31 with out_zero=1.
- Backpressure: 4 back-to-back inputs 0x1, 0x2, 0x4, 0x8 with out_ready=0 for 3 cycles -> in_ready low while the pipe is full. Outputs are 31, 30, 29, 28 in order, with no loss or duplication, and out_* is stable during the stall.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 after STAGES cycles.
- Reset mid-op: assert rst_n=0 asynchronously with 2 words in flight -> out_valid=0 immediately. After release, no output until a new input is accepted; the new result is correct.

Source files
------------

// File: rtl/lzd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lzd_pkg
//  Description : Shared types and elaboration-time helpers for the pipelined
//                leading-zero detector (lzd_pipe / lzd_merge).
//  Revision    : 1.0 - initial release
// ============================================================================
package lzd_pkg;

    // Widest tree supported: DATA_W up to 256 pads to 256 = 2^8
    localparam int LZD_MAX_LEVELS = 8;
    localparam int LZD_NODE_W     = LZD_MAX_LEVELS + 1;

    // Tree node: v = subtree holds a one, p = leading-zero count within the
    // subtree. A level-L node only uses p[L-1:0]; upper bits stay zero.
    typedef struct packed {
        logic                      v;
        logic [LZD_MAX_LEVELS-1:0] p;
    } lzd_node_t;

    // Ceiling log2, clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Input width rounded up to a power of two
    function automatic int lzd_pad_w(input int data_w);
        return 1 << clog2(data_w);
    endfunction

    // Number of merge levels in the tree
    function automatic int lzd_levels(input int data_w);
        return clog2(lzd_pad_w(data_w));
    endfunction

    // Count width able to hold 0..data_w
    function automatic int lzd_cnt_w(input int data_w);
        return clog2(data_w + 1);
    endfunction

    // Tree level after which stage register k sits
    function automatic int lzd_reg_level(input int k, input int levels, input int stages);
        return (k * levels + stages - 1) / stages;
    endfunction

    // True when one of the inner (non-output) registers follows this level
    function automatic bit lzd_reg_after(input int level, input int levels, input int stages);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k < stages; k++) begin
            if (lzd_reg_level(k, levels, stages) == level) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzd_merge.sv
`default_nettype none
// ============================================================================
//  Module      : lzd_merge
//  Description : One combinational node of the leading-zero merge tree.
//                Combines the (v, p) pair of an upper and a lower half into
//                the pair of the whole, at tree level LEVEL.
//  Revision    : 1.0 - initial release
// ============================================================================
module lzd_merge
    import lzd_pkg::*;
#(
    parameter int LEVEL = 1
) (
    input  logic [LZD_NODE_W-1:0] hi_i,
    input  logic [LZD_NODE_W-1:0] lo_i,
    output logic [LZD_NODE_W-1:0] node_o
);

    lzd_node_t w_hi;
    lzd_node_t w_lo;
    lzd_node_t w_node;

    assign w_hi = lzd_node_t'(hi_i);
    assign w_lo = lzd_node_t'(lo_i);

    // Upper half wins if it holds a one; otherwise its full width of zeros
    // (the new MSB of p) is added in front of the lower half's count
    always_comb begin
        w_node            = w_hi.v ? w_hi : w_lo;
        w_node.v          = w_hi.v | w_lo.v;
        w_node.p[LEVEL-1] = ~w_hi.v;
    end

    assign node_o = w_node;

endmodule
`default_nettype wire

// File: rtl/lzd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lzd_pipe
//  Description : Parametrised pipelined leading-zero detector with valid/ready
//                handshake and all-zero flag. Input is padded with ones at the
//                LSB end to a power of two and reduced by a (v, p) merge tree;
//                STAGES registers are spread across the tree levels, the last
//                one being the output register.
//                Optional macro LZD_NORM_EN adds out_norm = in_data << count.
//  Revision    : 1.0 - initial release
// ============================================================================
module lzd_pipe
    import lzd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [lzd_cnt_w(DATA_W)-1:0]  out_count,
    output logic                          out_zero
`ifdef LZD_NORM_EN
    ,
    output logic [DATA_W-1:0]             out_norm
`endif
);

    localparam int PAD_W  = lzd_pad_w(DATA_W);
    localparam int LEVELS = lzd_levels(DATA_W);
    localparam int CNT_W  = lzd_cnt_w(DATA_W);

    logic             out_valid_q;
    logic [CNT_W-1:0] count_q;
    logic             zero_q;
    logic             w_adv;
    logic [PAD_W-1:0] w_pad;

    // Global stall: every stage moves only when the output can be vacated
    assign w_adv    = ~out_valid_q | out_ready;
    assign in_ready = w_adv;

    // Ones below the LSB stop the scan early but never precede a real one
    if (PAD_W > DATA_W) begin : g_pad
        assign w_pad = {in_data, {(PAD_W-DATA_W){1'b1}}};
    end else begin : g_nopad
        assign w_pad = in_data;
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int N = PAD_W >> l;

        logic [LZD_NODE_W-1:0] w_node [N];
        logic [LZD_NODE_W-1:0] w_out  [N];
        logic                  w_vld_in;
        logic                  w_vld;
`ifdef LZD_NORM_EN
        logic [DATA_W-1:0]     w_dat_in;
        logic [DATA_W-1:0]     w_dat;
`endif

        if (l == 1) begin : g_src_in
            assign w_vld_in = in_valid;
`ifdef LZD_NORM_EN
            assign w_dat_in = in_data;
`endif
        end else begin : g_src_prev
            assign w_vld_in = g_lvl[l-1].w_vld;
`ifdef LZD_NORM_EN
            assign w_dat_in = g_lvl[l-1].w_dat;
`endif
        end

        for (genvar j = 0; j < N; j++) begin : g_node
            logic [LZD_NODE_W-1:0] w_hi;
            logic [LZD_NODE_W-1:0] w_lo;

            // Leaves treat each data bit as a one-bit subtree with p = 0
            if (l == 1) begin : g_leaf
                assign w_hi = {w_pad[2*j+1], {LZD_MAX_LEVELS{1'b0}}};
                assign w_lo = {w_pad[2*j],   {LZD_MAX_LEVELS{1'b0}}};
            end else begin : g_inner
                assign w_hi = g_lvl[l-1].w_out[2*j+1];
                assign w_lo = g_lvl[l-1].w_out[2*j];
            end

            lzd_merge #(
                .LEVEL (l)
            ) u_merge (
                .hi_i   (w_hi),
                .lo_i   (w_lo),
                .node_o (w_node[j])
            );
        end

        if (lzd_reg_after(l, LEVELS, STAGES)) begin : g_reg
            logic [LZD_NODE_W-1:0] node_q [N];
            logic                  vld_q;
`ifdef LZD_NORM_EN
            logic [DATA_W-1:0]     dat_q;
`endif

            // Inner pipeline register: nodes and valid bit shift together on adv
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    for (int i = 0; i < N; i++) node_q[i] <= '0;
`ifdef LZD_NORM_EN
                    dat_q <= '0;
`endif
                end else if (w_adv) begin
                    vld_q <= w_vld_in;
                    for (int i = 0; i < N; i++) node_q[i] <= w_node[i];
`ifdef LZD_NORM_EN
                    dat_q <= w_dat_in;
`endif
                end
            end

            assign w_out = node_q;
            assign w_vld = vld_q;
`ifdef LZD_NORM_EN
            assign w_dat = dat_q;
`endif
        end else begin : g_thru
            assign w_out = w_node;
            assign w_vld = w_vld_in;
`ifdef LZD_NORM_EN
            assign w_dat = w_dat_in;
`endif
        end
    end

    lzd_node_t        w_root;
    logic             w_root_vld;
    logic             zero_d;
    logic [CNT_W-1:0] count_d;

    assign w_root     = lzd_node_t'(g_lvl[LEVELS].w_out[0]);
    assign w_root_vld = g_lvl[LEVELS].w_vld;

    // With padding the root is never empty; an all-zero word then shows up as
    // a count landing exactly on the first padding bit (p == DATA_W)
    assign zero_d  = ~w_root.v | ({1'b0, w_root.p} == 9'(DATA_W));
    assign count_d = zero_d ? CNT_W'(DATA_W) : CNT_W'(w_root.p);

`ifdef LZD_NORM_EN
    logic [DATA_W-1:0] norm_q;
    logic [DATA_W-1:0] norm_d;

    assign norm_d = zero_d ? '0 : (g_lvl[LEVELS].w_dat << count_d);
`endif

    // Output register: result fields load only with a real word, so they
    // hold through bubbles and stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            count_q     <= '0;
            zero_q      <= 1'b0;
`ifdef LZD_NORM_EN
            norm_q      <= '0;
`endif
        end else if (w_adv) begin
            out_valid_q <= w_root_vld;
            if (w_root_vld) begin
                count_q <= count_d;
                zero_q  <= zero_d;
`ifdef LZD_NORM_EN
                norm_q  <= norm_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign out_zero  = zero_q;
`ifdef LZD_NORM_EN
    assign out_norm  = norm_q;
`endif

endmodule
`default_nettype wire
